// File: rtl/pg_tx_arb_pkg.sv
// rtl/pg_tx_arb_pkg.sv - shared types and helpers for the port-gasket TX arbiters
package pg_tx_arb_pkg;

    localparam int WEIGHT_W_DEF = 4;

    typedef logic [WEIGHT_W_DEF-1:0] t_arb_weight;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } t_arb_state;

    // A zero weight would starve its requester, so it is granted one packet per turn.
    function automatic logic [15:0] eff_weight(input logic [15:0] w);
        return (w == 16'd0) ? 16'd1 : w;
    endfunction

endpackage

// File: rtl/pg_rr_pick.sv
// rtl/pg_rr_pick.sv - rotating priority encoder: first set request at or above ptr_i, with wrap
module pg_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] gnt_o,
    output logic          any_o
);

    int s;

    // Scan from the farthest offset down so the nearest request to the pointer wins.
    always_comb begin
        gnt_o = ptr_i;
        any_o = 1'b0;
        s     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(ptr_i) + k;
            if (s >= N) begin
                s = s - N;
            end
            if (req_i[s]) begin
                gnt_o = IW'(s);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pg_tx_wrr_arb.sv
// rtl/pg_tx_wrr_arb.sv - packet-atomic WRR merge of NUM_REQ TX streams; PG_TX_ARB_STATS_EN adds counters
module pg_tx_wrr_arb
    import pg_tx_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 512,
    parameter int USER_W   = 10,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter logic [NUM_REQ*WEIGHT_W-1:0] ARB_WEIGHT = {NUM_REQ{WEIGHT_W'(1)}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           s_tvalid,
    output logic [NUM_REQ-1:0]           s_tready,
    input  logic [NUM_REQ*DATA_W-1:0]    s_tdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]  s_tkeep,
    input  logic [NUM_REQ*USER_W-1:0]    s_tuser,
    input  logic [NUM_REQ-1:0]           s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [DATA_W/8-1:0]          m_tkeep,
    output logic [USER_W-1:0]            m_tuser,
    output logic                         m_tlast,
    output logic [$clog2(NUM_REQ)-1:0]   m_grant_id
`ifdef PG_TX_ARB_STATS_EN
    ,
    input  logic                         stats_clr,
    output logic [NUM_REQ*32-1:0]        stats_pkt_cnt,
    output logic [31:0]                  stats_stall_cnt
`endif
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int KEEP_W = DATA_W / 8;

    function automatic logic [WEIGHT_W-1:0] weight_of(input logic [IDX_W-1:0] idx);
        return WEIGHT_W'(eff_weight(16'(ARB_WEIGHT[idx*WEIGHT_W +: WEIGHT_W])));
    endfunction

    t_arb_state           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]  credit_q, credit_d;
    logic                 pkt_end_q, pkt_end_d;

    logic                 m_tvalid_q, m_tlast_q;
    logic [DATA_W-1:0]    m_tdata_q;
    logic [KEEP_W-1:0]    m_tkeep_q;
    logic [USER_W-1:0]    m_tuser_q;
    logic [IDX_W-1:0]     m_grant_id_q;

    logic [IDX_W-1:0]     pick_idx, gnt_c, nxt_ptr;
    logic                 pick_any, active, out_rdy, accept, last_acc, release_c;
    logic [WEIGHT_W-1:0]  cred_c;

    pg_rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req_i (s_tvalid),
        .ptr_i (ptr_q),
        .gnt_o (pick_idx),
        .any_o (pick_any)
    );

    // In IDLE the freshly picked requester acts as the grant, so beat 0 is taken without a bubble.
    always_comb begin
        gnt_c  = grant_q;
        cred_c = credit_q;
        active = 1'b1;
        if (state_q == IDLE) begin
            gnt_c  = pick_idx;
            cred_c = weight_of(pick_idx);
            active = pick_any;
        end
    end

    assign out_rdy = ~m_tvalid_q | m_tready;

    always_comb begin
        s_tready = '0;
        if (active && rst_n) begin
            s_tready[gnt_c] = out_rdy;
        end
    end

    assign accept    = s_tvalid[gnt_c] & s_tready[gnt_c];
    assign last_acc  = accept & s_tlast[gnt_c];
    assign nxt_ptr   = (gnt_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_c + 1'b1;
    assign release_c = ((state_q == BUSY) && pkt_end_q && !s_tvalid[grant_q])
                     || (last_acc && (cred_c <= WEIGHT_W'(1)));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        credit_d  = credit_q;
        pkt_end_d = pkt_end_q;
        if ((state_q == IDLE) && pick_any) begin
            state_d   = BUSY;
            grant_d   = pick_idx;
            credit_d  = cred_c;
            pkt_end_d = 1'b0;
        end
        if (accept) begin
            pkt_end_d = s_tlast[gnt_c];
        end
        if (last_acc && (cred_c > WEIGHT_W'(1))) begin
            credit_d = cred_c - 1'b1;
        end
        if (release_c) begin
            state_d   = IDLE;
            ptr_d     = nxt_ptr;
            credit_d  = weight_of(nxt_ptr);
            pkt_end_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            credit_q     <= weight_of('0);
            pkt_end_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tuser_q    <= '0;
            m_grant_id_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            credit_q  <= credit_d;
            pkt_end_q <= pkt_end_d;
            if (out_rdy) begin
                m_tvalid_q <= accept;
                if (accept) begin
                    m_tlast_q    <= s_tlast[gnt_c];
                    m_tdata_q    <= s_tdata[gnt_c*DATA_W +: DATA_W];
                    m_tkeep_q    <= s_tkeep[gnt_c*KEEP_W +: KEEP_W];
                    m_tuser_q    <= s_tuser[gnt_c*USER_W +: USER_W];
                    m_grant_id_q <= gnt_c;
                end
            end
        end
    end

    assign m_tvalid   = m_tvalid_q;
    assign m_tlast    = m_tlast_q;
    assign m_tdata    = m_tdata_q;
    assign m_tkeep    = m_tkeep_q;
    assign m_tuser    = m_tuser_q;
    assign m_grant_id = m_grant_id_q;

`ifdef PG_TX_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] pkt_cnt_q;
    logic [31:0]           stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (stats_clr) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (last_acc && (pkt_cnt_q[gnt_c*32 +: 32] != 32'hFFFF_FFFF)) begin
                pkt_cnt_q[gnt_c*32 +: 32] <= pkt_cnt_q[gnt_c*32 +: 32] + 32'd1;
            end
            if (m_tvalid_q && !m_tready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stats_pkt_cnt   = pkt_cnt_q;
    assign stats_stall_cnt = stall_cnt_q;
`endif

endmodule
